// File: rtl/data_mem_if.sv
// MEM-stage data memory bus: address, store data, write/read enables and load data.
interface data_mem_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] mem_access_addr;
  logic [DATA_WIDTH-1:0] mem_write_data;
  logic                  mem_write_en;
  logic                  mem_read;
  logic [DATA_WIDTH-1:0] mem_read_data;

  modport master (
    output mem_access_addr, mem_write_data, mem_write_en, mem_read,
    input  mem_read_data
  );

  modport slave (
    input  mem_access_addr, mem_write_data, mem_write_en, mem_read,
    output mem_read_data
  );
endinterface

// File: rtl/data_mem.sv
// Word-addressed data memory: synchronous write, combinational gated read,
// single-cycle synchronous clear of every word.
module data_mem #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic       clk,
  input  logic       rst,
  data_mem_if.slave  bus
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q, mem_d;
  logic [DEPTH_LOG2-1:0]            idx;

  // Upper address bits are ignored so addresses wrap modulo the depth.
  assign idx = bus.mem_access_addr[DEPTH_LOG2-1:0];

  generate
    if (DEPTH_LOG2 < ADDR_WIDTH) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^bus.mem_access_addr[ADDR_WIDTH-1:DEPTH_LOG2];
    end
  endgenerate

  // An X on mem_write_en takes the false branch, leaving the array untouched.
  always_comb begin
    mem_d = mem_q;
    if (rst) begin
      mem_d = '0;
    end else if (bus.mem_write_en) begin
      mem_d[idx] = bus.mem_write_data;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // No write-through bypass: a same-cycle write shows up only after the edge.
  assign bus.mem_read_data = bus.mem_read ? mem_q[idx] : '0;
endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: directed vector table, hand-written corner
// sequences, and randomized traffic against an array-based reference model.
module tb_data_mem;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int DL = 8;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  data_mem_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  data_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH_LOG2(DL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic        we;
    logic        rd;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp;   // read data expected before the edge that follows
  } vec_t;

  vec_t vecs[$];
  logic [15:0] model [DEPTH];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic we, input logic rd,
                       input logic [15:0] a, input logic [15:0] d);
    rst                 = r;
    bus.mem_write_en    = we;
    bus.mem_read        = rd;
    bus.mem_access_addr = a;
    bus.mem_write_data  = d;
  endtask

  task automatic add(input string n, input logic r, input logic we, input logic rd,
                     input logic [15:0] a, input logic [15:0] d, input logic [15:0] e);
    vec_t v;
    v.name = n; v.rst = r; v.we = we; v.rd = rd; v.addr = a; v.wdata = d; v.exp = e;
    vecs.push_back(v);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);

    //   name              rst we rd addr     wdata    exp
    add("reset_out",       1, 0, 0, 16'h0000, 16'h0000, 16'h0000);
    add("after_reset",     0, 0, 1, 16'h0005, 16'h0000, 16'h0000);
    add("wr_beef",         0, 1, 0, 16'h0005, 16'hBEEF, 16'h0000);
    add("rd_beef",         0, 0, 1, 16'h0005, 16'h0000, 16'hBEEF);
    add("rst_pulse",       1, 0, 1, 16'h0005, 16'h0000, 16'hBEEF);
    add("reset_clear",     0, 0, 1, 16'h0005, 16'h0000, 16'h0000);
    add("wr_a1_old",       0, 1, 1, 16'h0001, 16'h0002, 16'h0000);
    add("basic_rd",        0, 0, 1, 16'h0001, 16'h0000, 16'h0002);
    add("rd_gated",        0, 0, 0, 16'h0001, 16'h0000, 16'h0000);
    add("rd_ungated",      0, 0, 1, 16'h0001, 16'h0000, 16'h0002);
    add("we_off_1",        0, 0, 1, 16'h0003, 16'h1234, 16'h0000);
    add("we_off_2",        0, 0, 1, 16'h0003, 16'h1234, 16'h0000);
    add("we_off_3",        0, 0, 1, 16'h0003, 16'h1234, 16'h0000);
    add("wr_wrap",         0, 1, 0, 16'h0102, 16'h00AA, 16'h0000);
    add("addr_wrap",       0, 0, 1, 16'h0002, 16'h0000, 16'h00AA);
    add("addr_wrap_hi",    0, 0, 1, 16'hFF02, 16'h0000, 16'h00AA);
    add("rst_vs_we",       1, 1, 1, 16'h0007, 16'h5555, 16'h0000);
    add("rst_priority",    0, 0, 1, 16'h0007, 16'h0000, 16'h0000);
    add("rst_cleared_a2",  0, 0, 1, 16'h0002, 16'h0000, 16'h0000);
    add("rst_cleared_a1",  0, 0, 1, 16'h0001, 16'h0000, 16'h0000);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].we, vecs[i].rd, vecs[i].addr, vecs[i].wdata);
      #1 check(vecs[i].name, bus.mem_read_data, vecs[i].exp);
      @(posedge clk);
      @(negedge clk);
    end

    // Read gating toggles with no clock edge in between.
    drive(1'b0, 1'b1, 1'b0, 16'h0009, 16'hC0DE);
    @(posedge clk); @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 16'h0009, 16'h0000);
    #1 check("gate_low", bus.mem_read_data, 16'h0000);
    bus.mem_read = 1'b1;
    #1 check("gate_high", bus.mem_read_data, 16'hC0DE);
    bus.mem_read = 1'b0;
    #1 check("gate_low_again", bus.mem_read_data, 16'h0000);

    // Same-address read+write: old word before the edge, new word right after.
    drive(1'b0, 1'b1, 1'b1, 16'h0009, 16'h7777);
    #1 check("rw_before_edge", bus.mem_read_data, 16'hC0DE);
    @(posedge clk); #1;
    check("rw_after_edge", bus.mem_read_data, 16'h7777);
    @(negedge clk);

    // Randomized traffic vs. reference model (starts from a clean reset).
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    @(posedge clk); @(negedge clk);
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    for (int n = 0; n < 600; n++) begin
      logic        r, we, rd;
      logic [15:0] a, d, exp;
      r  = ($urandom_range(0, 49) == 0);
      we = $urandom_range(0, 1);
      rd = ($urandom_range(0, 3) != 0);
      a  = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
      d  = 16'($urandom);
      drive(r, we, rd, a, d);
      exp = rd ? model[int'(a) % DEPTH] : 16'h0000;
      #1 check("rand_rd", bus.mem_read_data, exp);
      @(posedge clk);
      if (r) begin
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
      end else if (we) begin
        model[int'(a) % DEPTH] = d;
      end
      @(negedge clk);
    end

    // Sweep every word once after random traffic.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b0, 1'b1, 16'(i), 16'h0);
      #1 check("sweep_rd", bus.mem_read_data, model[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
